// File: rtl/timer_seq_pkg.sv
// Shared constants and state encoding for the interval-timer sequencer.
// Timer word addresses, control bits and FSM states.
package timer_seq_pkg;

  localparam logic [2:0] TMR_STATUS  = 3'd0;
  localparam logic [2:0] TMR_CONTROL = 3'd1;
  localparam logic [2:0] TMR_PERIODL = 3'd2;
  localparam logic [2:0] TMR_PERIODH = 3'd3;

  localparam logic [15:0] CTL_ITO   = 16'h0001;
  localparam logic [15:0] CTL_CONT  = 16'h0002;
  localparam logic [15:0] CTL_START = 16'h0004;
  localparam logic [15:0] CTL_STOP  = 16'h0008;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTL,
    S_WAIT_IRQ,
    S_STOP_TMR,
    S_CANCEL_CLR,
    S_CLR_STS,
    S_DONE
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request
// searching upward from i_ptr+1 with wrap.
module rr_arbiter
  import timer_seq_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic               o_valid,
  output logic [ID_W-1:0]    o_id
);

  int w_dist;
  int w_best;

  // Smallest wrapped distance past the pointer wins.
  always_comb begin
    o_valid = 1'b0;
    o_id    = '0;
    w_dist  = 0;
    w_best  = NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist = j - int'(i_ptr) - 1;
      if (w_dist < 0) w_dist = w_dist + NUM_REQ;
      if (i_req[j] && w_dist < w_best) begin
        w_best  = w_dist;
        o_valid = 1'b1;
        o_id    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/timer_sequencer.sv
// Shares one Avalon-MM interval timer among NUM_REQ requesters
// issuing one-shot delays, granted round-robin.
module timer_sequencer
  import timer_seq_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [32*NUM_REQ-1:0]   req_period,
  output logic [NUM_REQ-1:0]      done,
  output logic                    busy,
  output logic [ID_W-1:0]         active_id,
  output logic [2:0]              tmr_address,
  output logic                    tmr_chipselect,
  output logic                    tmr_write_n,
  output logic [15:0]             tmr_writedata,
  input  logic                    tmr_irq
);

  if (NUM_REQ > (1 << ID_W) || NUM_REQ < 2) begin : g_param_err
    $error("timer_sequencer: NUM_REQ out of range for ID_W");
  end

  state_e              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_id;
  logic [31:0]         r_period;
  logic [NUM_REQ-1:0]  r_done;
  logic                r_busy;
  logic [2:0]          r_addr;
  logic                r_cs;
  logic                r_wn;
  logic [15:0]         r_wdata;

  logic                w_valid;
  logic [ID_W-1:0]     w_id;
  logic [31:0]         w_period;
  logic                w_req_cur;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_valid (w_valid),
    .o_id    (w_id)
  );

  always_comb begin
    w_period  = '0;
    w_req_cur = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_id == ID_W'(i)) w_period = req_period[32*i +: 32];
      if (r_id == ID_W'(i)) w_req_cur = req[i];
    end
  end

  // Bus outputs are loaded on entry to each write state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= ID_W'(NUM_REQ - 1);
      r_id     <= '0;
      r_period <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
      r_addr   <= '0;
      r_cs     <= 1'b0;
      r_wn     <= 1'b1;
      r_wdata  <= '0;
    end else begin
      r_cs   <= 1'b0;
      r_wn   <= 1'b1;
      r_done <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_id     <= w_id;
            r_ptr    <= w_id;
            r_period <= w_period;
            r_busy   <= 1'b1;
            r_cs     <= 1'b1;
            r_wn     <= 1'b0;
            r_addr   <= TMR_PERIODL;
            r_wdata  <= w_period[15:0];
            r_state  <= S_WR_PL;
          end
        end
        S_WR_PL: begin
          r_cs    <= 1'b1;
          r_wn    <= 1'b0;
          r_addr  <= TMR_PERIODH;
          r_wdata <= r_period[31:16];
          r_state <= S_WR_PH;
        end
        S_WR_PH: begin
          r_cs    <= 1'b1;
          r_wn    <= 1'b0;
          r_addr  <= TMR_CONTROL;
          r_wdata <= CTL_ITO | CTL_START;
          r_state <= S_WR_CTL;
        end
        S_WR_CTL: r_state <= S_WAIT_IRQ;
        S_WAIT_IRQ: begin
          if (tmr_irq) begin
            r_cs    <= 1'b1;
            r_wn    <= 1'b0;
            r_addr  <= TMR_STATUS;
            r_wdata <= '0;
            r_state <= S_CLR_STS;
          end else if (!w_req_cur) begin
            r_cs    <= 1'b1;
            r_wn    <= 1'b0;
            r_addr  <= TMR_CONTROL;
            r_wdata <= CTL_STOP;
            r_state <= S_STOP_TMR;
          end
        end
        S_STOP_TMR: begin
          r_cs    <= 1'b1;
          r_wn    <= 1'b0;
          r_addr  <= TMR_STATUS;
          r_wdata <= '0;
          r_state <= S_CANCEL_CLR;
        end
        S_CANCEL_CLR: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_CLR_STS: begin
          r_done  <= NUM_REQ'(1) << r_id;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign done           = r_done;
  assign busy           = r_busy;
  assign active_id      = r_id;
  assign tmr_address    = r_addr;
  assign tmr_chipselect = r_cs;
  assign tmr_write_n    = r_wn;
  assign tmr_writedata  = r_wdata;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed and randomized bench for timer_sequencer with a
// cycle-level interval-timer model and round-robin reference.
module tb_timer_sequencer;

  localparam int N  = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req;
  logic [32*N-1:0]   req_period;
  logic [N-1:0]      done;
  logic              busy;
  logic [IW-1:0]     active_id;
  logic [2:0]        tmr_address;
  logic              tmr_chipselect;
  logic              tmr_write_n;
  logic [15:0]       tmr_writedata;
  logic              tmr_irq;

  always #5 clk = ~clk;

  timer_sequencer #(
    .NUM_REQ (N),
    .ID_W    (IW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .req_period     (req_period),
    .done           (done),
    .busy           (busy),
    .active_id      (active_id),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_irq        (tmr_irq)
  );

  typedef struct {
    int a;
    int d;
    int c;
  } wr_t;

  wr_t         wlog[$];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          irq_cyc;
  int          done_cyc;
  int          ptr;
  bit          done_seen;
  logic [N-1:0] done_val;
  bit          tm_run;
  bit          tm_irq_m;
  bit          irq_force;
  longint      tm_rem;
  logic [15:0] tm_pl;
  logic [15:0] tm_ph;

  task automatic chk(string tag, longint obs, longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: observe bus at negedge, run the timer model.
  task automatic step();
    bit prev;
    @(negedge clk);
    cyc++;
    if (tm_run) begin
      tm_rem--;
      if (tm_rem == 0) begin
        tm_irq_m = 1'b1;
        tm_run   = 1'b0;
      end
    end
    if (tmr_chipselect && !tmr_write_n) begin
      wlog.push_back('{a: int'(tmr_address), d: int'(tmr_writedata), c: cyc});
      case (tmr_address)
        3'd0: tm_irq_m = 1'b0;
        3'd1: begin
          if (tmr_writedata[3]) tm_run = 1'b0;
          if (tmr_writedata[2]) begin
            tm_run = 1'b1;
            tm_rem = longint'({tm_ph, tm_pl}) + 1;
          end
        end
        3'd2: tm_pl = tmr_writedata;
        3'd3: tm_ph = tmr_writedata;
        default: ;
      endcase
    end
    prev    = tmr_irq;
    tmr_irq = tm_irq_m | irq_force;
    if (tmr_irq && !prev) irq_cyc = cyc;
    if (done != '0) begin
      done_seen = 1'b1;
      done_val  = done;
      done_cyc  = cyc;
      req       = req & ~done;
    end
  endtask

  function automatic wr_t wl(int i);
    wr_t none = '{a: -1, d: -1, c: -1};
    if (i < wlog.size()) return wlog[i];
    return none;
  endfunction

  function automatic longint pk(wr_t w);
    return longint'(w.a) * 65536 + longint'(w.d);
  endfunction

  function automatic int rr_pick(int p, logic [N-1:0] m);
    for (int k = 1; k <= N; k++) begin
      if (m[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // One full grant-to-done transaction for requester id.
  task automatic expect_txn(int id, logic [31:0] p, bit drop_irq);
    int bad = 0;
    int t = 0;
    done_seen = 1'b0;
    done_val  = '0;
    irq_cyc   = -1000;
    done_cyc  = -2000;
    wlog.delete();
    while (!done_seen && t < 40 + int'(p)) begin
      step();
      t++;
      if (drop_irq && tmr_irq && irq_cyc == cyc) req[id] = 1'b0;
      if (wlog.size() == 1) req_period[32*id +: 32] = $urandom;
      if (wlog.size() > 0 && (!busy || active_id != IW'(id))) bad++;
    end
    chk("done_seen", longint'(done_seen), 1);
    chk("done_id", longint'(done_val), longint'(1) << id);
    chk("nwrites", wlog.size(), 4);
    chk("wr_pl", pk(wl(0)), 2 * 65536 + longint'(p[15:0]));
    chk("wr_ph", pk(wl(1)), 3 * 65536 + longint'(p[31:16]));
    chk("wr_ctl", pk(wl(2)), 1 * 65536 + 5);
    chk("wr_sts", pk(wl(3)), 0);
    chk("ph_cyc", wl(1).c - wl(0).c, 1);
    chk("ctl_cyc", wl(2).c - wl(0).c, 2);
    chk("sts_cyc", done_cyc - wl(3).c, 1);
    chk("irq_lat", done_cyc - wl(2).c, longint'(p) + 3);
    chk("irq2done", done_cyc - irq_cyc, 2);
    chk("busy_id_hold", bad, 0);
    step();
    chk("done_1cyc", longint'(done), 0);
  endtask

  task automatic grant_all(logic [N-1:0] mask);
    logic [N-1:0] m;
    int id;
    m   = mask;
    req = req | mask;
    while (m != '0) begin
      id  = rr_pick(ptr, m);
      ptr = id;
      expect_txn(id, req_period[32*id +: 32], 1'b0);
      m[id] = 1'b0;
    end
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_id"}, longint'(active_id), 0);
    chk({tag, "_cs"}, longint'(tmr_chipselect), 0);
    chk({tag, "_wn"}, longint'(tmr_write_n), 1);
    chk({tag, "_addr"}, longint'(tmr_address), 0);
    chk({tag, "_wdata"}, longint'(tmr_writedata), 0);
  endtask

  initial begin
    int s;
    int t;
    logic [N-1:0] m;

    reset_n    = 1'b0;
    req        = '0;
    req_period = '0;
    tmr_irq    = 1'b0;
    irq_force  = 1'b0;
    tm_run     = 1'b0;
    tm_irq_m   = 1'b0;
    tm_rem     = 0;
    tm_pl      = '0;
    tm_ph      = '0;
    ptr        = N - 1;
    step();
    chk_reset_vals("reset");
    step();
    reset_n = 1'b1;
    step();

    // Round-robin from reset pointer, then 0 before 1.
    for (int i = 0; i < N; i++)
      req_period[32*i +: 32] = 32'($urandom_range(0, 6));
    grant_all(4'b1011);
    req_period[31:0]  = 32'd2;
    req_period[63:32] = 32'd1;
    grant_all(4'b0011);

    // Single request, period 9.
    req_period[63:32] = 32'h0000_0009;
    grant_all(4'b0010);

    // Cancel 5 cycles after START.
    wlog.delete();
    done_seen = 1'b0;
    req_period[95:64] = 32'h0001_0000;
    req[2] = 1'b1;
    ptr = 2;
    t = 0;
    while (wlog.size() < 3 && t < 20) begin
      step();
      t++;
    end
    chk("cancel_start", pk(wl(2)), 1 * 65536 + 5);
    s = wl(2).c;
    repeat (5) step();
    req[2] = 1'b0;
    repeat (4) step();
    chk("cancel_nwr", wlog.size(), 5);
    chk("cancel_stop", pk(wl(3)), 1 * 65536 + 8);
    chk("cancel_stop_cyc", wl(3).c - s, 6);
    chk("cancel_clr", pk(wl(4)), 0);
    chk("cancel_clr_cyc", wl(4).c - s, 7);
    chk("cancel_busy", longint'(busy), 0);
    chk("cancel_nodone", longint'(done_seen), 0);

    // Irq and cancel coincide: done path wins.
    req_period[127:96] = 32'd4;
    req[3] = 1'b1;
    ptr = 3;
    expect_txn(3, 32'd4, 1'b1);

    // Spurious irq while idle.
    wlog.delete();
    irq_force = 1'b1;
    repeat (3) step();
    irq_force = 1'b0;
    step();
    chk("spur_busy", longint'(busy), 0);
    chk("spur_nwr", wlog.size(), 0);

    // Period zero.
    req_period[31:0] = 32'd0;
    grant_all(4'b0001);

    // Wide period, then cancel.
    wlog.delete();
    done_seen = 1'b0;
    req_period[63:32] = 32'hABCD_1234;
    req[1] = 1'b1;
    ptr = 1;
    t = 0;
    while (wlog.size() < 3 && t < 20) begin
      step();
      t++;
    end
    chk("wide_pl", pk(wl(0)), 2 * 65536 + 32'h1234);
    chk("wide_ph", pk(wl(1)), 3 * 65536 + 32'hABCD);
    chk("wide_ctl", pk(wl(2)), 1 * 65536 + 5);
    step();
    req[1] = 1'b0;
    t = 0;
    do begin
      step();
      t++;
    end while (busy && t < 10);
    chk("wide_idle", longint'(busy), 0);
    chk("wide_nodone", longint'(done_seen), 0);

    // Reset during WAIT_IRQ.
    wlog.delete();
    req_period[95:64] = 32'd50;
    req[2] = 1'b1;
    t = 0;
    while (wlog.size() < 3 && t < 20) begin
      step();
      t++;
    end
    repeat (4) step();
    chk("pre_rst_busy", longint'(busy), 1);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("midrst");
    req      = '0;
    tm_run   = 1'b0;
    tm_irq_m = 1'b0;
    tmr_irq  = 1'b0;
    ptr      = N - 1;
    step();
    reset_n = 1'b1;
    step();
    req_period[63:32] = 32'd2;
    req_period[95:64] = 32'd3;
    grant_all(4'b0110);

    // Randomized rounds against the reference model.
    for (int r = 0; r < 8; r++) begin
      m = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++)
        req_period[32*i +: 32] = 32'($urandom_range(0, 15));
      grant_all(m);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
